framebuf_ctrl: RTL and testbench
================================

FRAMEBUF_CTRL -- requirements
Module: framebuf_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, pixel width in bits.
REQ-002 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-004 SHALL have parameter ADDR_WIDTH, default 19, BRAM address width; must satisfy 2^ADDR_WIDTH >= H_ACTIVE*V_ACTIVE.
REQ-005 SHALL have port i_clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port o_rd, output, 1, input FIFO read enable.
REQ-008 SHALL have port i_rdata, input, DATA_WIDTH+1, input FIFO data; bit DATA_WIDTH = start-of-frame (SOF) tag, low bits = pixel.
REQ-009 SHALL have port i_empty, input, 1, input FIFO empty flag.
REQ-010 SHALL have port o_wr, output, 1, output FIFO write enable.
REQ-011 SHALL have port o_wdata, output, DATA_WIDTH, output FIFO write data.
REQ-012 SHALL have port i_almostfull, input, 1, output FIFO almost-full flag.
REQ-013 SHALL have port i_req, input, 1, one-cycle frame readout request from the display side.
REQ-014 SHALL have port o_frame_done, output, 1, one-cycle pulse after the last pixel of a readout frame is written.
REQ-015 SHALL have port o_frame_cnt, output, 16, count of SOFs received, wraps at 2^16.
REQ-016 SHALL have port o_wr_ovf, output, 1, sticky flag: pixel arrived beyond H_ACTIVE*V_ACTIVE-1 in one frame.

Function
REQ-017 SHALL assert o_rd whenever i_empty is low; input FIFO read data is valid the cycle after o_rd.
REQ-018 SHALL discard all pixels until the first SOF-tagged pixel after reset.
REQ-019 SHALL write an SOF-tagged pixel at address 0 and each subsequent pixel at address+1.
REQ-020 SHALL drop pixels whose address would exceed H_ACTIVE*V_ACTIVE-1 (no wrap) and set o_wr_ovf until reset.
REQ-021 SHALL increment o_frame_cnt by 1 on every accepted SOF pixel.
REQ-022 SHALL implement the frame store as a simple dual-port BRAM, one write and one read port, read-first on same-address collision.
REQ-023 SHALL implement readout FSM states R_IDLE, R_ACTIVE, R_DONE.
REQ-024 SHALL move R_IDLE -> R_ACTIVE on i_req, with read address cleared to 0.
REQ-025 SHALL, in R_ACTIVE, issue one BRAM read per cycle while i_almostfull is low and stall while it is high.
REQ-026 SHALL assert o_wr with o_wdata exactly one cycle after each issued BRAM read, including the read issued on the stall-entry cycle.
REQ-027 SHALL move R_ACTIVE -> R_DONE after H_ACTIVE*V_ACTIVE reads are issued, and R_DONE -> R_IDLE after the final o_wr cycle, pulsing o_frame_done for one cycle.
REQ-028 SHALL ignore i_req outside R_IDLE.
REQ-029 SHALL carry out a write and a readout in the same cycle independently.

Reset
REQ-030 SHALL, while i_rstn is low, force o_rd=0, o_wr=0, o_wdata=0, o_frame_done=0, o_frame_cnt=0, o_wr_ovf=0, FSM=R_IDLE, addresses=0 and the SOF-seen flag=0.
REQ-031 SHALL abandon any in-flight readout or frame write on reset; BRAM contents are not cleared.

Configuration
REQ-032 SHALL, with macro FRAMEBUF_DOUBLE_EN defined, use two banks (address MSB = bank): writer bank W and ready bank L. On each SOF after the first, L<=W, and W toggles unless the reader is in R_ACTIVE on bank ~W, in which case W is kept and that frame is overwritten. i_req latches the read bank from L.
REQ-033 SHALL, without FRAMEBUF_DOUBLE_EN, use a single bank that the reader and writer share, with tearing permitted.

Verification
REQ-034 SHALL use H_ACTIVE=4, V_ACTIVE=2 and feed 3 untagged pixels then SOF+0x001..0x008 -> first three dropped, BRAM[0..7]=0x001..0x008, o_frame_cnt=1.
REQ-035 SHALL feed SOF plus 10 pixels (H=4,V=2) -> 8 stored, o_wr_ovf=1 from the 9th pixel and held through the next SOF.
REQ-036 SHALL pulse i_req after a full frame with i_almostfull=0 -> 8 consecutive o_wr beats starting 2 cycles after i_req, then o_frame_done=1 for one cycle.
REQ-037 SHALL hold i_almostfull=1 for 5 cycles mid-readout -> no pixel lost or duplicated; total o_wr count=8, order preserved.
REQ-038 SHALL, with FRAMEBUF_DOUBLE_EN, write frame A, start readout, then write frame B mid-readout -> readout returns frame A unmodified; the next i_req returns frame B.
REQ-039 SHALL deassert i_rstn during R_ACTIVE -> all outputs 0 next edge; a fresh i_req after release reads from address 0.

Source files
------------

// File: rtl/framebuf_ctrl.sv
// framebuf_ctrl -- frame store between a pixel input FIFO and a display output FIFO.
//
// Pixels arrive from the input FIFO tagged with a start-of-frame bit. After the
// first SOF they are written into a BRAM frame store, starting at address 0.
// On a one-cycle readout request, the stored frame is streamed into the output
// FIFO in address order. Streaming pauses while the output FIFO is almost full.
//
// Optional feature: define FRAMEBUF_DOUBLE_EN to make the store double-buffered.
// The bank is the MSB of the BRAM address. Without the macro, reader and writer
// share one bank, and tearing is allowed.
//
// Ports
//   i_clk, i_rstn     : clock (rising edge), asynchronous active-low reset
//   o_rd              : input FIFO read enable; data is valid the following cycle
//   i_rdata, i_empty  : input FIFO data ({sof, pixel}) and empty flag
//   o_wr, o_wdata     : output FIFO write enable and pixel data
//   i_almostfull      : output FIFO back-pressure
//   i_req             : one-cycle readout request
//   o_frame_done      : one-cycle pulse after the last readout pixel is written
//   o_frame_cnt       : number of accepted SOF pixels (wraps)
//   o_wr_ovf          : sticky, a frame carried more pixels than the store holds
module framebuf_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_rd,
  input  logic [DATA_WIDTH:0]   i_rdata,
  input  logic                  i_empty,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull,
  input  logic                  i_req,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_wr_ovf
);

  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_WIDTH:0]   PIX_CNT   = (ADDR_WIDTH+1)'(NPIX);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
`ifdef FRAMEBUF_DOUBLE_EN
  localparam int MEM_AW = ADDR_WIDTH + 1;
`else
  localparam int MEM_AW = ADDR_WIDTH;
`endif

  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_DONE} rstate_t;

  logic                  rd_valid_q, rd_valid_d;
  logic                  sof_seen_q, sof_seen_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  wr_ovf_q, wr_ovf_d;
  rstate_t               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_q, wr_d;
  logic                  frame_done_q, frame_done_d;
  logic                  mem_we;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] wr_offset;
  logic [MEM_AW-1:0]     mem_waddr, mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
`ifdef FRAMEBUF_DOUBLE_EN
  logic wbank_q, wbank_d, lbank_q, lbank_d, rbank_q, rbank_d;
`endif

  // Read whenever data is available. The reset term keeps o_rd low during reset.
  assign o_rd       = i_rstn & ~i_empty;
  assign rd_valid_d = o_rd;

  // Write side. An SOF restarts at address 0.
  // Untagged pixels advance the address until the frame is full.
  // Extra pixels are dropped and flag an overflow.
  always_comb begin
    sof_seen_d  = sof_seen_q;
    wr_cnt_d    = wr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wr_ovf_d    = wr_ovf_q;
    mem_we      = 1'b0;
    wr_offset   = wr_cnt_q[ADDR_WIDTH-1:0];
`ifdef FRAMEBUF_DOUBLE_EN
    wbank_d     = wbank_q;
    lbank_d     = lbank_q;
`endif
    if (rd_valid_q) begin
      if (i_rdata[DATA_WIDTH]) begin
        mem_we      = 1'b1;
        wr_offset   = '0;
        wr_cnt_d    = (ADDR_WIDTH+1)'(1);
        frame_cnt_d = frame_cnt_q + 16'd1;
        sof_seen_d  = 1'b1;
`ifdef FRAMEBUF_DOUBLE_EN
        // The finished frame becomes the ready bank. The writer moves to the
        // other bank only if the reader is not currently draining it.
        if (sof_seen_q) begin
          lbank_d = wbank_q;
          if (!(rstate_q == R_ACTIVE && rbank_q != wbank_q)) begin
            wbank_d = ~wbank_q;
          end
        end
`endif
      end else if (sof_seen_q) begin
        if (wr_cnt_q < PIX_CNT) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + (ADDR_WIDTH+1)'(1);
        end else begin
          wr_ovf_d = 1'b1;
        end
      end
    end
  end

  // Readout FSM. A read is issued on every ACTIVE cycle without back-pressure.
  // The BRAM output register gives the one-cycle delay to o_wr.
  always_comb begin
    rstate_d     = rstate_q;
    rd_addr_d    = rd_addr_q;
    frame_done_d = 1'b0;
    rd_issue     = 1'b0;
`ifdef FRAMEBUF_DOUBLE_EN
    rbank_d      = rbank_q;
`endif
    case (rstate_q)
      R_IDLE: begin
        if (i_req) begin
          rstate_d  = R_ACTIVE;
          rd_addr_d = '0;
`ifdef FRAMEBUF_DOUBLE_EN
          rbank_d   = lbank_q;
`endif
        end
      end
      R_ACTIVE: begin
        if (!i_almostfull) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          if (rd_addr_q == LAST_ADDR) begin
            rstate_d = R_DONE;
          end
        end
      end
      R_DONE: begin
        rstate_d     = R_IDLE;
        frame_done_d = 1'b1;
      end
      default: rstate_d = R_IDLE;
    endcase
    wr_d = rd_issue;
  end

`ifdef FRAMEBUF_DOUBLE_EN
  assign mem_waddr = {wbank_d, wr_offset};
  assign mem_raddr = {rbank_q, rd_addr_q};
`else
  assign mem_waddr = wr_offset;
  assign mem_raddr = rd_addr_q;
`endif

  // Simple dual-port BRAM. Nonblocking semantics make a same-address access
  // return the old contents (read-first). There is no reset, so the stored
  // frame survives a reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= i_rdata[DATA_WIDTH-1:0];
    end
    if (rd_issue) begin
      mem_rdata_q <= mem[mem_raddr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_valid_q   <= 1'b0;
      sof_seen_q   <= 1'b0;
      wr_cnt_q     <= '0;
      frame_cnt_q  <= '0;
      wr_ovf_q     <= 1'b0;
      rstate_q     <= R_IDLE;
      rd_addr_q    <= '0;
      wr_q         <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FRAMEBUF_DOUBLE_EN
      wbank_q      <= 1'b0;
      lbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
`endif
    end else begin
      rd_valid_q   <= rd_valid_d;
      sof_seen_q   <= sof_seen_d;
      wr_cnt_q     <= wr_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_ovf_q     <= wr_ovf_d;
      rstate_q     <= rstate_d;
      rd_addr_q    <= rd_addr_d;
      wr_q         <= wr_d;
      frame_done_q <= frame_done_d;
`ifdef FRAMEBUF_DOUBLE_EN
      wbank_q      <= wbank_d;
      lbank_q      <= lbank_d;
      rbank_q      <= rbank_d;
`endif
    end
  end

  // The BRAM output register has no reset, so the data output is gated to zero when idle.
  assign o_wr         = wr_q;
  assign o_wdata      = wr_q ? mem_rdata_q : '0;
  assign o_frame_done = frame_done_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_wr_ovf     = wr_ovf_q;

endmodule

// File: tb/tb_framebuf_ctrl.sv
// tb_framebuf_ctrl -- self-checking bench for framebuf_ctrl with a 4x2 frame.
// A queue stands in for the input FIFO. A frame-level model tracks the
// expected store contents, frame count and overflow flag.
`timescale 1ns/1ps
module tb_framebuf_ctrl;

  localparam int DW   = 12;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int AW   = 3;
  localparam int NPIX = H * V;
`ifdef FRAMEBUF_DOUBLE_EN
  localparam bit DOUBLE = 1'b1;
`else
  localparam bit DOUBLE = 1'b0;
`endif

  typedef logic [DW-1:0] frame_t [NPIX];

  logic          clk = 1'b0;
  logic          rstn;
  logic          o_rd;
  logic [DW:0]   i_rdata;
  logic          i_empty;
  logic          o_wr;
  logic [DW-1:0] o_wdata;
  logic          i_almostfull;
  logic          i_req;
  logic          o_frame_done;
  logic [15:0]   o_frame_cnt;
  logic          o_wr_ovf;

  int checks;
  int errors;

  // input FIFO model
  logic [DW:0] in_q[$];
  logic        rd_seen;
  logic        gap_en;

  // frame-level reference model
  logic [DW-1:0] m_mem [2][NPIX];
  int            m_wb, m_lb, m_addr, m_cnt;
  bit            m_seen, m_ovf, m_rd_active;
  int            m_rd_bank;

  framebuf_ctrl #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .o_rd        (o_rd),
    .i_rdata     (i_rdata),
    .i_empty     (i_empty),
    .o_wr        (o_wr),
    .o_wdata     (o_wdata),
    .i_almostfull(i_almostfull),
    .i_req       (i_req),
    .o_frame_done(o_frame_done),
    .o_frame_cnt (o_frame_cnt),
    .o_wr_ovf    (o_wr_ovf)
  );

  always #5 clk = ~clk;

  // Input FIFO: a read seen during a cycle pops one word after the edge.
  initial rd_seen = 1'b0;
  always @(negedge clk) rd_seen = o_rd;
  always @(posedge clk) begin
    #1;
    if (rd_seen && in_q.size() > 0) i_rdata = in_q.pop_front();
    i_empty = (in_q.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_lb = 0; m_addr = 0; m_cnt = 0;
    m_seen = 1'b0; m_ovf = 1'b0; m_rd_active = 1'b0; m_rd_bank = 0;
  endtask

  // Frame-level model: SOF restarts at 0; excess pixels are dropped and flagged.
  // In double mode the completed frame is published and the writer changes bank
  // unless the reader currently owns the other bank.
  task automatic model_feed(input bit sof, input logic [DW-1:0] pix);
    if (sof) begin
      if (DOUBLE && m_seen) begin
        m_lb = m_wb;
        if (!(m_rd_active && m_rd_bank != m_wb)) m_wb = 1 - m_wb;
      end
      m_seen = 1'b1;
      m_cnt  = (m_cnt + 1) % 65536;
      m_mem[m_wb][0] = pix;
      m_addr = 1;
    end else if (m_seen) begin
      if (m_addr < NPIX) begin
        m_mem[m_wb][m_addr] = pix;
        m_addr++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit sof, input logic [DW-1:0] pix);
    in_q.push_back({sof, pix});
    model_feed(sof, pix);
  endtask

  task automatic push_frame(input frame_t f);
    for (int i = 0; i < NPIX; i++) applyStimulus(i == 0, f[i]);
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < NPIX; i++) f[i] = DW'($urandom_range(0, 4095));
  endtask

  task automatic snap(input int bank, output frame_t f);
    for (int i = 0; i < NPIX; i++) f[i] = m_mem[bank][i];
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (in_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_drain"}, 32'(in_q.size()), 32'd0);
  endtask

  // Pulse i_req, then collect o_wr beats until o_frame_done (bounded).
  // Optionally add back-pressure, a second i_req, or a frame pushed mid-readout.
  task automatic run_readout(input string tag, input frame_t exp, input int stall_at,
                             input int stall_len, input bit req_again,
                             input bit push_mid, input frame_t mid_frame);
    int  cyc, nwr, first, last, done_cyc;
    bit  pushed;
    nwr = 0; first = -1; last = -1; done_cyc = -1; pushed = 1'b0;
    @(posedge clk); #1;
    i_req = 1'b1;
    m_rd_active = 1'b1;
    m_rd_bank   = m_lb;
    @(posedge clk); #1;
    i_req = 1'b0;
    cyc = 1;
    i_almostfull = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
    while (cyc < 150 && done_cyc < 0) begin
      @(negedge clk);
      if (o_wr) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (nwr < NPIX) checkOutput({tag, "_pix"}, 32'(o_wdata), 32'(exp[nwr]));
        nwr++;
      end
      if (o_frame_done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
      i_req = req_again && (cyc == 4);
      i_almostfull = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      if (push_mid && !pushed && cyc == stall_at + 1) begin
        push_frame(mid_frame);
        pushed = 1'b1;
      end
    end
    i_req = 1'b0;
    i_almostfull = 1'b0;
    m_rd_active = 1'b0;
    checkOutput({tag, "_beats"}, 32'(nwr), 32'(NPIX));
    if (stall_len == 0 || stall_at >= 2) checkOutput({tag, "_latency"}, 32'(first), 32'd2);
    if (stall_len == 0) checkOutput({tag, "_burst"}, 32'(last), 32'(first + NPIX - 1));
    checkOutput({tag, "_done_at"}, 32'(done_cyc), 32'(last + 1));
    @(negedge clk);
    checkOutput({tag, "_done_width"}, 32'(o_frame_done), 32'd0);
  endtask

  initial begin
    frame_t exp_f, fa, fb, none;
    checks = 0; errors = 0;
    rstn = 1'b0; i_req = 1'b0; i_almostfull = 1'b0; gap_en = 1'b0;
    i_empty = 1'b1; i_rdata = '0;
    model_reset();
    rand_frame(none);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr", 32'(o_wr), 32'd0);
    checkOutput("rst_wdata", 32'(o_wdata), 32'd0);
    checkOutput("rst_done", 32'(o_frame_done), 32'd0);
    checkOutput("rst_cnt", 32'(o_frame_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(o_wr_ovf), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // pixels before the first SOF are discarded
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'($urandom_range(0, 4095)));
    for (int i = 1; i <= NPIX; i++) applyStimulus(i == 1, DW'(i));
    drain("first");
    checkOutput("first_cnt", 32'(o_frame_cnt), 32'd1);
    checkOutput("first_ovf", 32'(o_wr_ovf), 32'd0);
    for (int i = 0; i < NPIX; i++) exp_f[i] = DW'(i + 1);
    $display("[TB] readout of first frame");
    run_readout("seq", exp_f, 0, 0, 1'b0, 1'b0, none);

    // overflow: SOF plus 10 pixels
    gap_en = 1'b1;
    applyStimulus(1'b1, DW'($urandom_range(0, 4095)));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, DW'($urandom_range(0, 4095)));
    drain("ovf");
    checkOutput("ovf_set", 32'(o_wr_ovf), 32'd1);
    checkOutput("ovf_cnt", 32'(o_frame_cnt), 32'(m_cnt));
    snap(m_lb, exp_f);
    run_readout("ovf_rd", exp_f, 0, 0, 1'b0, 1'b0, none);

    // random frames with back-pressure, the flag stays set through new SOFs
    for (int k = 0; k < 3; k++) begin
      rand_frame(fa);
      push_frame(fa);
      drain("rnd");
      checkOutput("ovf_held", 32'(o_wr_ovf), 32'd1);
      checkOutput("rnd_cnt", 32'(o_frame_cnt), 32'(m_cnt));
      snap(m_lb, exp_f);
      run_readout("stall", exp_f, $urandom_range(2, 8), 5, 1'b1, 1'b0, none);
    end
    gap_en = 1'b0;

    // reset during an active readout
    @(posedge clk); #1;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    checkOutput("arst_wr", 32'(o_wr), 32'd0);
    checkOutput("arst_wdata", 32'(o_wdata), 32'd0);
    checkOutput("arst_cnt", 32'(o_frame_cnt), 32'd0);
    checkOutput("arst_ovf", 32'(o_wr_ovf), 32'd0);
    @(negedge clk);
    checkOutput("arst_done", 32'(o_frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_wr", 32'(o_wr), 32'd0);
    snap(m_lb, exp_f);
    run_readout("post_rst", exp_f, 0, 0, 1'b0, 1'b0, none);

`ifdef FRAMEBUF_DOUBLE_EN
    // double buffer: frame B arrives while frame A is being read out
    rand_frame(fa);
    rand_frame(fb);
    push_frame(fa);
    drain("dbl_a");
    applyStimulus(1'b1, DW'($urandom_range(0, 4095)));
    drain("dbl_pad");
    run_readout("dbl_a", fa, 1, 30, 1'b0, 1'b1, fb);
    drain("dbl_b");
    applyStimulus(1'b1, DW'($urandom_range(0, 4095)));
    drain("dbl_c");
    run_readout("dbl_b", fb, 0, 0, 1'b0, 1'b0, none);
    checkOutput("dbl_cnt", 32'(o_frame_cnt), 32'(m_cnt));
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
